adder30_arbiter: RTL and testbench



---
 rtl/adder30_arbiter_if.sv | 31 +++
 rtl/adder30_arbiter.sv | 96 +++++++++
 tb/tb_adder30_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder30_arbiter_if.sv
// Bundle between the two requesters, the shared adder and the arbiter.
// The master side is the integration; the slave side is the arbiter.
interface adder30_arbiter_if #(
  parameter int WIDTH = 30
);
  logic             flush;
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt1;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic [WIDTH-1:0] adder_sum;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_id;

  modport master (
    output flush, req0, a0, b0, req1, a1, b1, adder_sum,
    input  gnt0, gnt1, adder_a, adder_b, res, res_valid, res_id
  );

  modport slave (
    input  flush, req0, a0, b0, req1, a1, b1, adder_sum,
    output gnt0, gnt1, adder_a, adder_b, res, res_valid, res_id
  );
endinterface

// File: rtl/adder30_arbiter.sv
// Round-robin time-sharing of one ripple-carry adder between the
// PC incrementer (id 0) and the branch-target calculator (id 1).
module adder30_arbiter #(
  parameter int WIDTH = 30
) (
  input logic             clk,
  input logic             rst,
  adder30_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cur_id_q, cur_id_d;
  logic             last_id_q, last_id_d;
  logic             res_id_q, res_id_d;
  logic             win;

  // Next-state: arbitrate when free, capture the sum after ISSUE.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    res_id_d  = res_id_q;
    win       = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.req0 || bus.req1) begin
          // On a tie the requester that did not win last time goes.
          win       = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;
          op_a_d    = win ? bus.a1 : bus.a0;
          op_b_d    = win ? bus.b1 : bus.b0;
          cur_id_d  = win;
          last_id_d = win;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          res_d    = bus.adder_sum;
          res_id_d = cur_id_q;
          state_d  = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      cur_id_q  <= 1'b0;
      last_id_q <= 1'b1;
      res_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
      res_id_q  <= res_id_d;
    end
  end

  // Pulses come from the state register only; the adder sees
  // registered operands so its inputs never glitch.
  assign bus.gnt0      = (state_q == ISSUE) && !cur_id_q;
  assign bus.gnt1      = (state_q == ISSUE) && cur_id_q;
  assign bus.res_valid = (state_q == RESP);
  assign bus.adder_a   = op_a_q;
  assign bus.adder_b   = op_b_q;
  assign bus.res       = res_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_adder30_arbiter.sv
// Self-checking bench for adder30_arbiter: directed scenarios plus a
// randomized run against a cycle-indexed transaction model.
module tb_adder30_arbiter;
  localparam int W = 30;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  adder30_arbiter_if #(.WIDTH(W)) bus ();

  adder30_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.adder_sum = bus.adder_a + bus.adder_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.flush = 0; bus.req0 = 0; bus.req1 = 0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    tick();
    tick();
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b%b%b exp=000", bus.gnt0, bus.gnt1, bus.res_valid);
    end
    checks++;
    if (bus.res !== '0 || bus.res_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_res got=%h/%b exp=0/0", bus.res, bus.res_id);
    end
    checks++;
    if (bus.adder_a !== '0 || bus.adder_b !== '0) begin
      failures++;
      $display("FAIL reset_adder got=%h/%h exp=0/0", bus.adder_a, bus.adder_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bus.req0 = 1; bus.a0 = 30'h0000_1000; bus.b0 = 30'h1;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt got=%b%b exp=10", bus.gnt0, bus.gnt1);
    end
    checks++;
    if (bus.adder_a !== 30'h1000 || bus.adder_b !== 30'h1) begin
      failures++;
      $display("FAIL single_adder got=%h/%h exp=1000/1", bus.adder_a, bus.adder_b);
    end
    bus.req0 = 0;
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res !== 30'h1001 || bus.res_id !== 1'b0) begin
      failures++;
      $display("FAIL single_res got=%b %h %b exp=1 1001 0", bus.res_valid, bus.res, bus.res_id);
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got=%b%b exp=00", bus.res_valid, bus.gnt0);
    end
  endtask

  task automatic test_wrap;
    bus.req1 = 1; bus.a1 = 30'h3FFF_FFFF; bus.b1 = 30'h2;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_gnt got=%b%b exp=01", bus.gnt0, bus.gnt1);
    end
    bus.req1 = 0;
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res !== 30'h1 || bus.res_id !== 1'b1) begin
      failures++;
      $display("FAIL wrap_res got=%b %h %b exp=1 1 1", bus.res_valid, bus.res, bus.res_id);
    end
    tick();
  endtask

  task automatic test_contention;
    logic         lastw;
    logic         w;
    logic [W-1:0] exp_sum;
    lastw = 1'b1;
    bus.req0 = 1; bus.a0 = W'($urandom); bus.b0 = W'($urandom);
    bus.req1 = 1; bus.a1 = W'($urandom); bus.b1 = W'($urandom);
    for (int i = 0; i < 8; i++) begin
      tick();
      w = ~lastw;
      lastw = w;
      checks++;
      if (bus.gnt0 !== !w || bus.gnt1 !== w || bus.res_valid !== 1'b0) begin
        failures++;
        $display("FAIL contention_gnt op=%0d got=%b%b exp=%b%b", i, bus.gnt0, bus.gnt1, !w, w);
      end
      if (w) begin
        exp_sum = bus.a1 + bus.b1;
        bus.a1 = W'($urandom); bus.b1 = W'($urandom);
      end else begin
        exp_sum = bus.a0 + bus.b0;
        bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      end
      tick();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res !== exp_sum || bus.res_id !== w) begin
        failures++;
        $display("FAIL contention_res op=%0d got=%b %h %b exp=1 %h %b", i, bus.res_valid, bus.res, bus.res_id, exp_sum, w);
      end
      if (i == 7) begin
        bus.req0 = 0;
        bus.req1 = 0;
      end
    end
    tick();
  endtask

  task automatic test_flush;
    bus.req0 = 1; bus.a0 = 30'h123; bus.b0 = 30'h456;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL flush_issue_gnt got=%b exp=1", bus.gnt0);
    end
    bus.req0 = 0;
    bus.flush = 1;
    tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_res got=%b exp=0", bus.res_valid);
    end
    bus.flush = 0;
    bus.req0 = 1; bus.req1 = 1;
    bus.a1 = 30'h2000_0000; bus.b1 = 30'h0000_0777;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL flush_next_gnt got=%b%b exp=01", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res !== 30'h2000_0777 || bus.res_id !== 1'b1) begin
      failures++;
      $display("FAIL flush_next_res got=%b %h %b exp=1 20000777 1", bus.res_valid, bus.res, bus.res_id);
    end
    tick();
    bus.req0 = 1; bus.flush = 1;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL flush_coincident got=%b%b exp=00", bus.gnt0, bus.gnt1);
    end
    bus.flush = 0;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL flush_after_gnt got=%b exp=1", bus.gnt0);
    end
    bus.req0 = 0;
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res !== 30'h579) begin
      failures++;
      $display("FAIL flush_after_res got=%b %h exp=1 579", bus.res_valid, bus.res);
    end
    tick();
  endtask

  task automatic test_stability;
    bus.req0 = 1; bus.a0 = 30'h0ABC_DEF0; bus.b0 = 30'h111;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL stab_gnt got=%b exp=1", bus.gnt0);
    end
    bus.a0 = 30'h3000_0000;
    bus.req0 = 0;
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res !== 30'h0ABC_E001 || bus.res_id !== 1'b0) begin
      failures++;
      $display("FAIL stab_res got=%b %h %b exp=1 0abce001 0", bus.res_valid, bus.res, bus.res_id);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.req0 = 1; bus.a0 = 30'h5; bus.b0 = 30'h6;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.adder_a !== 30'h5) begin
      failures++;
      $display("FAIL rmid_issue got=%b %h exp=1 5", bus.gnt0, bus.adder_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res !== '0 || bus.res_id !== 1'b0 || bus.adder_a !== '0 || bus.adder_b !== '0) begin
      failures++;
      $display("FAIL rmid_async got=%b%b%b %h %b %h %h exp=000 0 0 0 0", bus.gnt0, bus.gnt1,
               bus.res_valid, bus.res, bus.res_id, bus.adder_a, bus.adder_b);
    end
    bus.req0 = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.res_valid !== 1'b0) begin
        failures++;
        $display("FAIL rmid_no_res cyc=%0d got=%b exp=0", i, bus.res_valid);
      end
    end
    bus.req0 = 1; bus.req1 = 1;
    tick();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL rmid_first_tie got=%b%b exp=10", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick();
    tick();
  endtask

  task automatic test_random;
    logic         acc_prev;
    logic         acc_now;
    logic         last_w;
    logic         w;
    logic         rv_exp;
    logic         g0e, g1e;
    logic         s_req0, s_req1, s_flush;
    logic [W-1:0] s_a0, s_b0, s_a1, s_b1;
    logic [W-1:0] pend_sum, exp_a, exp_b;
    logic         pend_id;
    bus.req0 = 0; bus.req1 = 0; bus.flush = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_prev = 1'b0;
    last_w = 1'b1;
    pend_sum = '0; pend_id = 1'b0; exp_a = '0; exp_b = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      s_req0 = bus.req0; s_req1 = bus.req1; s_flush = bus.flush;
      s_a0 = bus.a0; s_b0 = bus.b0; s_a1 = bus.a1; s_b1 = bus.b1;
      tick();
      rv_exp = acc_prev && !s_flush;
      acc_now = !s_flush && !acc_prev && (s_req0 || s_req1);
      g0e = 1'b0; g1e = 1'b0;
      if (rv_exp) begin
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res !== pend_sum || bus.res_id !== pend_id) begin
          failures++;
          $display("FAIL rand_res cyc=%0d got=%b %h %b exp=1 %h %b", cyc, bus.res_valid, bus.res, bus.res_id, pend_sum, pend_id);
        end
      end
      if (acc_now) begin
        w = (s_req0 && s_req1) ? ~last_w : s_req1;
        last_w = w;
        exp_a = w ? s_a1 : s_a0;
        exp_b = w ? s_b1 : s_b0;
        pend_sum = exp_a + exp_b;
        pend_id = w;
        g0e = !w;
        g1e = w;
        checks++;
        if (bus.adder_a !== exp_a || bus.adder_b !== exp_b) begin
          failures++;
          $display("FAIL rand_adder cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.adder_a, bus.adder_b, exp_a, exp_b);
        end
      end
      acc_prev = acc_now;
      checks++;
      if (bus.gnt0 !== g0e || bus.gnt1 !== g1e || bus.res_valid !== rv_exp) begin
        failures++;
        $display("FAIL rand_pulses cyc=%0d got=%b%b%b exp=%b%b%b", cyc, bus.gnt0, bus.gnt1, bus.res_valid, g0e, g1e, rv_exp);
      end
      if (!acc_now) begin
        checks++;
        if (bus.adder_a !== exp_a || bus.adder_b !== exp_b) begin
          failures++;
          $display("FAIL rand_adder_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.adder_a, bus.adder_b, exp_a, exp_b);
        end
      end
      if (g0e) begin
        bus.req0 = 0; bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1;
        bus.a0 = ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF : W'($urandom);
        bus.b0 = W'($urandom);
      end
      if (g1e) begin
        bus.req1 = 0; bus.a1 = W'($urandom); bus.b1 = W'($urandom);
      end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1;
        bus.a1 = W'($urandom);
        bus.b1 = ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF : W'($urandom);
      end
      bus.flush = ($urandom_range(0, 9) == 0);
    end
    bus.req0 = 0; bus.req1 = 0; bus.flush = 0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_flush();
    test_stability();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
